// File: rtl/sm_accum_pkg.sv
// Shared sign-magnitude helpers for the scaling and accumulation stages.
// Provides default word widths, the accumulator state type and conversion functions.
package sm_pkg;

    localparam int SM_WIDTH = 32;
    localparam int SM_ACC_W = 40;
    localparam logic [SM_WIDTH-2:0] SM_MAG_MAX = '1;

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } sm_state_t;

    typedef struct packed {
        logic                sat;
        logic [SM_WIDTH-1:0] data;
    } sm_sat_t;

    function automatic logic [SM_ACC_W-1:0] sm_to_tc(input logic [SM_WIDTH-1:0] sm);
        logic [SM_ACC_W-1:0] mag;
        mag = SM_ACC_W'(sm[SM_WIDTH-2:0]);
        return sm[SM_WIDTH-1] ? -mag : mag;
    endfunction

    // Zero always comes out with a positive sign because a zero sum has bit 39 clear.
    function automatic sm_sat_t tc_to_sm_sat(input logic [SM_ACC_W-1:0] tc);
        logic [SM_ACC_W-1:0] mag;
        sm_sat_t             res;
        mag      = tc[SM_ACC_W-1] ? -tc : tc;
        res.sat  = |mag[SM_ACC_W-1:SM_WIDTH-1];
        res.data = {tc[SM_ACC_W-1], res.sat ? SM_MAG_MAX : mag[SM_WIDTH-2:0]};
        return res;
    endfunction

endpackage

// File: rtl/sm_accum_if.sv
// Term/result stream bundle between a producer (master) and sm_accum (slave).
interface sm_accum_if
    import sm_pkg::*;
#(
    parameter int WIDTH = SM_WIDTH,
    parameter int CNT_W = 8
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_sat;
    logic [CNT_W-1:0] out_terms;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_sat, out_terms
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_sat, out_terms
    );

endinterface

// File: rtl/sm_accum_sm_to_tc_conv.sv
// Combinational sign-magnitude to two's-complement converter, widened to ACC_W.
module sm_to_tc_conv
    import sm_pkg::*;
#(
    parameter int WIDTH = SM_WIDTH,
    parameter int ACC_W = SM_ACC_W
) (
    input  logic [WIDTH-1:0] sm,
    output logic [ACC_W-1:0] tc
);

    logic [ACC_W-1:0] mag_ext;

    assign mag_ext = ACC_W'(sm[WIDTH-2:0]);
    // Negative zero negates to zero, so it needs no special case.
    assign tc      = sm[WIDTH-1] ? -mag_ext : mag_ext;

endmodule

// File: rtl/sm_accum.sv
// Packet accumulator: sums sign-magnitude terms, emits one saturated sign-magnitude result per packet.
//   state | meaning
//   ACC   | accepting terms, no result pending
//   HOLD  | result presented on out_*, terms still accepted when out_ready=1
module sm_accum
    import sm_pkg::*;
#(
    parameter int WIDTH = SM_WIDTH,
    parameter int ACC_W = SM_ACC_W,
    parameter int CNT_W = 8
) (
    input  logic     clk,
    input  logic     rst,
    sm_accum_if.slave bus
);

    sm_state_t        state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic [ACC_W-1:0] term;
    logic [ACC_W-1:0] sum;
    logic [ACC_W-1:0] sum_abs;
    logic             sum_neg;
    logic             sum_sat;
    logic [WIDTH-2:0] sum_mag;
    logic [CNT_W-1:0] cnt_inc;
    logic             accept;

    sm_to_tc_conv #(
        .WIDTH (WIDTH),
        .ACC_W (ACC_W)
    ) u_conv (
        .sm (bus.in_data),
        .tc (term)
    );

    assign bus.in_ready = (state == ACC) || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;

    assign sum     = acc + term;
    assign cnt_inc = (&cnt) ? cnt : cnt + CNT_W'(1);

    assign sum_neg = sum[ACC_W-1];
    assign sum_abs = sum_neg ? -sum : sum;
    assign sum_sat = |sum_abs[ACC_W-1:WIDTH-1];
    assign sum_mag = sum_sat ? '1 : sum_abs[WIDTH-2:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ACC;
            acc           <= '0;
            cnt           <= '0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_sat   <= 1'b0;
            bus.out_terms <= '0;
        end else begin
            if (accept) begin
                if (bus.in_last) begin
                    bus.out_data  <= {sum_neg, sum_mag};
                    bus.out_sat   <= sum_sat;
                    bus.out_terms <= cnt_inc;
                    bus.out_valid <= 1'b1;
                    acc           <= '0;
                    cnt           <= '0;
                    state         <= HOLD;
                end else begin
                    acc <= sum;
                    cnt <= cnt_inc;
                end
            end
            // A consumed result drops out of HOLD unless a new one replaces it this cycle.
            if (state == HOLD && bus.out_ready && !(accept && bus.in_last)) begin
                state         <= ACC;
                bus.out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sm_accum.sv
// Self-checking bench for sm_accum: directed packets plus randomized packets against a plain-arithmetic model.
module tb_sm_accum;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    sm_accum_if #(.WIDTH(32), .CNT_W(8)) bus ();

    sm_accum #(
        .WIDTH (32),
        .ACC_W (40),
        .CNT_W (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic last);
        int waitc;
        waitc         = 0;
        bus.in_valid  = 1'b1;
        bus.in_data   = d;
        bus.in_last   = last;
        #1;
        while (!bus.in_ready && waitc < 20) begin
            tick();
            waitc++;
        end
        chk("in_ready before accept", 64'(bus.in_ready), 64'd1);
        tick();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    // Reference: exact integer sum of the packet, then sign-magnitude with clipping.
    function automatic void ref_pkt(input logic [31:0] t[$], output logic [31:0] d,
                                    output logic s, output logic [7:0] n);
        longint total;
        longint a;
        total = 0;
        foreach (t[i]) begin
            if (t[i][31]) total -= longint'(t[i][30:0]);
            else          total += longint'(t[i][30:0]);
        end
        a = (total < 0) ? -total : total;
        s = (a > 64'sh7FFFFFFF);
        d = {(total < 0), s ? 31'h7FFFFFFF : a[30:0]};
        n = (t.size() > 255) ? 8'd255 : 8'(t.size());
    endfunction

    task automatic run_pkt(input logic [31:0] t[$], input logic [31:0] ed,
                           input logic es, input logic [7:0] en, input string tag);
        foreach (t[i]) send(t[i], (i == t.size() - 1));
        chk({tag, " out_valid"}, 64'(bus.out_valid), 64'd1);
        chk({tag, " out_data"},  64'(bus.out_data),  64'(ed));
        chk({tag, " out_sat"},   64'(bus.out_sat),   64'(es));
        chk({tag, " out_terms"}, 64'(bus.out_terms), 64'(en));
    endtask

    initial begin
        logic [31:0] q[$];
        logic [31:0] ed;
        logic        es;
        logic [7:0]  en;
        logic [31:0] mag;

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("reset out_valid", 64'(bus.out_valid), 64'd0);
        chk("reset out_data",  64'(bus.out_data),  64'd0);
        chk("reset out_sat",   64'(bus.out_sat),   64'd0);
        chk("reset out_terms", 64'(bus.out_terms), 64'd0);
        chk("reset in_ready",  64'(bus.in_ready),  64'd1);

        q.delete(); q.push_back(32'h00000064); q.push_back(32'h8000001E); q.push_back(32'h00000005);
        run_pkt(q, 32'h0000004B, 1'b0, 8'd3, "mixed");

        q.delete(); q.push_back(32'h0000000A); q.push_back(32'h80000019);
        run_pkt(q, 32'h8000000F, 1'b0, 8'd2, "negative");

        q.delete(); q.push_back(32'h80000000);
        run_pkt(q, 32'h00000000, 1'b0, 8'd1, "negzero");

        q.delete(); q.push_back(32'h7FFFFFFF); q.push_back(32'h7FFFFFFF);
        run_pkt(q, 32'h7FFFFFFF, 1'b1, 8'd2, "sat pos");

        q.delete(); q.push_back(32'hFFFFFFFF); q.push_back(32'hFFFFFFFF);
        run_pkt(q, 32'hFFFFFFFF, 1'b1, 8'd2, "sat neg");

        // Backpressure, then a term accepted on the release cycle.
        tick();
        bus.out_ready = 1'b0;
        q.delete(); q.push_back(32'h00000001); q.push_back(32'h00000002);
        run_pkt(q, 32'h00000003, 1'b0, 8'd2, "bp pkt");
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h00000007;
        bus.in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp in_ready",  64'(bus.in_ready),  64'd0);
            chk("bp out_valid", 64'(bus.out_valid), 64'd1);
            chk("bp out_data",  64'(bus.out_data),  64'h3);
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        chk("b2b out_valid", 64'(bus.out_valid), 64'd1);
        chk("b2b out_data",  64'(bus.out_data),  64'h7);
        chk("b2b out_terms", 64'(bus.out_terms), 64'd1);
        tick();
        chk("idle out_valid", 64'(bus.out_valid), 64'd0);

        // Reset in the middle of a packet.
        send(32'h00000010, 1'b0);
        send(32'h00000020, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst out_valid", 64'(bus.out_valid), 64'd0);
        chk("midrst in_ready",  64'(bus.in_ready),  64'd1);
        q.delete(); q.push_back(32'h00000003);
        run_pkt(q, 32'h00000003, 1'b0, 8'd1, "after rst");

        // Randomized packets, back-to-back, with occasional output stalls.
        for (int p = 0; p < 40; p++) begin
            q.delete();
            for (int k = 0, len = $urandom_range(1, 6); k < len; k++) begin
                if ($urandom_range(0, 7) == 0) mag = 32'h7FFF0000 | ($urandom & 32'hFFFF);
                else                           mag = $urandom_range(0, 100000);
                q.push_back({1'($urandom_range(0, 1)), mag[30:0]});
            end
            ref_pkt(q, ed, es, en);
            run_pkt(q, ed, es, en, "random");
            if ($urandom_range(0, 3) == 0) begin
                bus.out_ready = 1'b0;
                for (int s = 0, h = $urandom_range(1, 3); s < h; s++) begin
                    tick();
                    chk("stall out_valid", 64'(bus.out_valid), 64'd1);
                    chk("stall out_data",  64'(bus.out_data),  64'(ed));
                    chk("stall in_ready",  64'(bus.in_ready),  64'd0);
                end
                bus.out_ready = 1'b1;
            end
        end

        // Term count saturates at 255.
        q.delete();
        for (int k = 0; k < 300; k++) begin
            mag = $urandom_range(0, 1000);
            q.push_back({1'($urandom_range(0, 1)), mag[30:0]});
        end
        ref_pkt(q, ed, es, en);
        run_pkt(q, ed, es, en, "long pkt");

        tick();
        chk("final out_valid", 64'(bus.out_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
